// File: rtl/uart_tx_fifo_if.sv
// Bus bundle for uart_tx_fifo.
//   master : the producer side. It drives wr_data and wr_en, and it observes
//            full, empty, count, busy and tx.
//   slave  : the transmitter side. It receives wr_data and wr_en, and it drives
//            the status signals and the serial line.
// count is log2(FIFO_DEPTH)+1 bits wide, so it can hold the value FIFO_DEPTH.
interface uart_tx_fifo_if #(
    parameter int FIFO_DEPTH = 8
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [7:0]       wr_data;
    logic             wr_en;
    logic             full;
    logic             empty;
    logic [CNT_W-1:0] count;
    logic             busy;
    logic             tx;

    modport master (
        output wr_data, wr_en,
        input  full, empty, count, busy, tx
    );

    modport slave (
        input  wr_data, wr_en,
        output full, empty, count, busy, tx
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmitter with a transmit FIFO in front of it. The frame format is
// 8N1, with the data bits sent LSB first.
// Ports:
//   clk   : system clock; all logic runs on its rising edge
//   reset : asynchronous, active-high reset
//   bus   : uart_tx_fifo_if.slave. It carries these signals:
//             wr_data / wr_en : enqueue one byte per cycle in which wr_en is high
//             full / empty    : FIFO status
//             count           : bytes waiting in the FIFO; the byte being
//                               shifted out is not counted
//             busy            : high whenever the FSM is not in IDLE
//             tx              : registered serial line, high when idle
//
// state | meaning
// IDLE  | line high, waiting for a byte in the FIFO
// START | start bit (0) on the line
// DATA  | data bit bit_q on the line
// STOP  | stop bit (1) on the line; at its end, chain into the next byte if
//       | one is queued
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 10417,
    parameter int FIFO_DEPTH   = 8
) (
    input logic          clk,
    input logic          reset,
    uart_tx_fifo_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_LOAD = BW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state_q, state_d;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count_q;
    logic [7:0]    shift_q;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic          tx_q, tx_d;
    logic          pop;
    logic          wr_ok;
    logic          full, empty;

    // Status comes from the registered count only, so wr_en has no
    // combinational path to full, empty or count.
    assign full  = (count_q == DEPTH_C);
    assign empty = (count_q == '0);
    assign wr_ok = bus.wr_en && !full;

    assign bus.full  = full;
    assign bus.empty = empty;
    assign bus.count = count_q;
    assign bus.busy  = (state_q != IDLE);
    assign bus.tx    = tx_q;

    // The baud timer counts down from CLKS_PER_BIT-1. Each bit ends on the
    // cycle in which the timer reads zero.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        tx_d    = tx_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = START;
                    baud_d  = BAUD_LOAD;
                    tx_d    = 1'b0;
                end
            end
            START: begin
                if (baud_q == '0) begin
                    state_d = DATA;
                    bit_d   = 3'd0;
                    baud_d  = BAUD_LOAD;
                    tx_d    = shift_q[0];
                end else begin
                    baud_d = baud_q - BW'(1);
                end
            end
            DATA: begin
                if (baud_q == '0) begin
                    baud_d = BAUD_LOAD;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d = bit_q + 3'd1;
                        tx_d  = shift_q[bit_q + 3'd1];
                    end
                end else begin
                    baud_d = baud_q - BW'(1);
                end
            end
            STOP: begin
                if (baud_q == '0) begin
                    if (!empty) begin
                        pop     = 1'b1;
                        state_d = START;
                        baud_d  = BAUD_LOAD;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = IDLE;
                        tx_d    = 1'b1;
                    end
                end else begin
                    baud_d = baud_q - BW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= 3'd0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
        end
    end

    // The byte is copied into shift_q when it is popped. A later write that
    // lands on the freed slot therefore cannot disturb the frame in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            shift_q <= 8'h00;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop) begin
                rd_ptr  <= rd_ptr + AW'(1);
                shift_q <= mem[rd_ptr];
            end
            if (wr_ok && !pop)      count_q <= count_q + CW'(1);
            else if (!wr_ok && pop) count_q <= count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr] <= bus.wr_data;
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
module tb_uart_tx_fifo;
    logic clk = 1'b0;
    logic reset;

    int vectors     = 0;
    int miscompares = 0;
    logic [7:0] sb[$];

    uart_tx_fifo_if #(.FIFO_DEPTH(8)) bus ();

    uart_tx_fifo #(.CLKS_PER_BIT(4), .FIFO_DEPTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // The write is presented at a negedge and is sampled at the next posedge.
    // The task returns 1 ns after that posedge.
    task automatic write_byte(input logic [7:0] b, input bit accepted);
        @(negedge clk);
        bus.wr_data = b;
        bus.wr_en   = 1'b1;
        if (accepted) sb.push_back(b);
        @(posedge clk);
        #1;
        bus.wr_en = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk);
            #1;
            if (!bus.busy && bus.empty) begin
                ok = 1'b1;
                break;
            end
        end
        check(tag, 32'(ok), 32'd1);
    endtask

    // Frame monitor. A frame is detected at the first negedge on which tx is
    // low. From that point the line must follow the 10-bit frame built from
    // the scoreboard head, holding each bit for exactly 4 cycles.
    always begin : monitor
        logic [9:0] frame;
        logic [7:0] exp_b;
        logic [7:0] got_b;
        int         bad;
        bit         aborted;
        bit         have_exp;
        @(negedge clk);
        if (!reset && bus.tx === 1'b0) begin
            have_exp = (sb.size() > 0);
            exp_b    = have_exp ? sb[0] : 8'h00;
            frame    = {1'b1, exp_b, 1'b0};
            bad      = 0;
            aborted  = 1'b0;
            got_b    = 8'h00;
            for (int c = 0; c < 40; c++) begin
                if (c > 0) @(negedge clk);
                if (reset) begin
                    aborted = 1'b1;
                    break;
                end
                if (bus.tx !== frame[c/4]) bad++;
                if (c >= 4 && c < 36 && (c % 4) == 2) got_b[(c-4)/4] = bus.tx;
            end
            if (!aborted) begin
                check("frame_expected", 32'(have_exp), 32'd1);
                if (have_exp) exp_b = sb.pop_front();
                check("frame_data", 32'(got_b), 32'(exp_b));
                check("frame_timing", 32'(bad), 32'd0);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, miscompares=%0d", miscompares);
        $fatal(1, "watchdog");
    end

    initial begin
        reset       = 1'b1;
        bus.wr_en   = 1'b0;
        bus.wr_data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx", 32'(bus.tx), 32'd1);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_empty", 32'(bus.empty), 32'd1);
        check("rst_full", 32'(bus.full), 32'd0);
        check("rst_count", 32'(bus.count), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Single byte: 0x41 written at edge N.
        write_byte(8'h41, 1'b1);
        check("sb_count_n", 32'(bus.count), 32'd1);
        check("sb_empty_n", 32'(bus.empty), 32'd0);
        check("sb_tx_n", 32'(bus.tx), 32'd1);
        check("sb_busy_n", 32'(bus.busy), 32'd0);
        @(posedge clk); #1;
        check("sb_tx_n1", 32'(bus.tx), 32'd0);
        check("sb_busy_n1", 32'(bus.busy), 32'd1);
        check("sb_count_n1", 32'(bus.count), 32'd0);
        repeat (39) @(posedge clk); #1;
        check("sb_busy_n40", 32'(bus.busy), 32'd1);
        check("sb_stop_n40", 32'(bus.tx), 32'd1);
        @(posedge clk); #1;
        check("sb_busy_n41", 32'(bus.busy), 32'd0);
        check("sb_empty_n41", 32'(bus.empty), 32'd1);

        // Back-to-back writes. The 0xAA write lands on the same edge as the
        // 0x55 pop, so count holds at 1.
        write_byte(8'h55, 1'b1);
        check("b2b_count_n", 32'(bus.count), 32'd1);
        write_byte(8'hAA, 1'b1);
        check("b2b_count_n1", 32'(bus.count), 32'd1);
        check("b2b_tx_n1", 32'(bus.tx), 32'd0);
        repeat (39) @(posedge clk); #1;
        check("b2b_stop1", 32'(bus.tx), 32'd1);
        check("b2b_count_n40", 32'(bus.count), 32'd1);
        @(posedge clk); #1;
        check("b2b_start2", 32'(bus.tx), 32'd0);
        check("b2b_count_n41", 32'(bus.count), 32'd0);
        repeat (39) @(posedge clk); #1;
        check("b2b_busy_n80", 32'(bus.busy), 32'd1);
        @(posedge clk); #1;
        check("b2b_busy_n81", 32'(bus.busy), 32'd0);

        // Overflow: 0x00 is popped on the edge where 0x01 is written, so the
        // FIFO fills on 0x08 and 0x09 is dropped.
        for (int i = 0; i < 9; i++) write_byte(8'(i), 1'b1);
        check("ovf_count", 32'(bus.count), 32'd8);
        check("ovf_full", 32'(bus.full), 32'd1);
        write_byte(8'h09, 1'b0);
        check("ovf_drop_count", 32'(bus.count), 32'd8);
        check("ovf_drop_full", 32'(bus.full), 32'd1);
        repeat (31) @(posedge clk); #1;
        check("ovf_full_hold", 32'(bus.full), 32'd1);
        @(posedge clk); #1;
        check("ovf_full_fall", 32'(bus.full), 32'd0);
        check("ovf_count_pop", 32'(bus.count), 32'd7);
        wait_idle("ovf_idle");

        // Simultaneous write and pop with count=3, on the edge where STOP ends.
        for (int i = 0; i < 4; i++) write_byte(8'hA0 + 8'(i), 1'b1);
        check("sim_count_pre", 32'(bus.count), 32'd3);
        repeat (37) @(posedge clk);
        write_byte(8'hA4, 1'b1);
        check("sim_count_post", 32'(bus.count), 32'd3);
        check("sim_tx_start", 32'(bus.tx), 32'd0);
        wait_idle("sim_idle");

        // Wrap-around: 20 bytes, one per frame.
        for (int i = 0; i < 20; i++) begin
            write_byte(8'h10 + 8'(i), 1'b1);
            wait_idle("wrap_idle");
        end

        // Reset during bit 3 of 0xF0, with two bytes still queued.
        write_byte(8'hF0, 1'b1);
        write_byte(8'h11, 1'b1);
        write_byte(8'h22, 1'b1);
        repeat (15) @(posedge clk);
        #2;
        check("mid_tx_bit3", 32'(bus.tx), 32'd0);
        check("mid_count", 32'(bus.count), 32'd2);
        reset = 1'b1;
        #1;
        check("mid_rst_tx", 32'(bus.tx), 32'd1);
        check("mid_rst_count", 32'(bus.count), 32'd0);
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
        check("mid_rst_empty", 32'(bus.empty), 32'd1);
        sb.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        write_byte(8'h7E, 1'b1);
        check("post_count_n", 32'(bus.count), 32'd1);
        check("post_tx_n", 32'(bus.tx), 32'd1);
        @(posedge clk); #1;
        check("post_tx_n1", 32'(bus.tx), 32'd0);
        check("post_busy_n1", 32'(bus.busy), 32'd1);
        repeat (39) @(posedge clk); #1;
        check("post_busy_n40", 32'(bus.busy), 32'd1);
        @(posedge clk); #1;
        check("post_busy_n41", 32'(bus.busy), 32'd0);

        wait_idle("final_idle");
        repeat (2) @(posedge clk);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
